// File: rtl/rtc_write_sequencer.sv
// rtc_write_sequencer: commits one time/date/timer group to the RTC as packed-BCD bus writes.
// Defining RTCW_XFER_CMD_EN appends one transfer-command write (XFER_ADDR <- 8'h00).
module rtc_write_sequencer #(
    parameter int         PHASE_CYCLES = 4,
    parameter logic [7:0] TIME_BASE    = 8'h21,
    parameter logic [7:0] DATE_BASE    = 8'h24,
    parameter logic [7:0] TIMER_BASE   = 8'h41,
    parameter logic [7:0] XFER_ADDR    = 8'hF1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] group,
    input  logic [7:0] val_1,
    input  logic [7:0] val_2,
    input  logic [7:0] val_3,
    output logic       busy,
    output logic       done,
    output logic [7:0] bus_ad,
    output logic       bus_oe,
    output logic       cs_n,
    output logic       wr_n,
    output logic       a_d
);

    localparam int            CW       = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);
`ifdef RTCW_XFER_CMD_EN
    localparam logic [1:0]    LAST_IDX = 2'd3;
`else
    localparam logic [1:0]    LAST_IDX = 2'd2;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_GAP_A = 3'd2,
        S_DATA  = 3'd3,
        S_GAP_D = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    function automatic logic [7:0] to_bcd(input logic [7:0] bin);
        logic [7:0] tens;
        logic [7:0] ones;
        tens = bin / 8'd10;
        ones = bin % 8'd10;
        if (bin > 8'd99) begin
            to_bcd = 8'h99;
        end else begin
            to_bcd = {tens[3:0], ones[3:0]};
        end
    endfunction

    // Index 3 only occurs when the transfer command is enabled.
    function automatic logic [7:0] reg_addr(input logic [1:0] grp, input logic [1:0] idx);
        logic [7:0] base;
        case (grp)
            2'd3:    base = TIME_BASE;
            2'd2:    base = DATE_BASE;
            default: base = TIMER_BASE;
        endcase
        case (idx)
            2'd0:    reg_addr = base;
            2'd1:    reg_addr = base + 8'd1;
            2'd2:    reg_addr = base + 8'd2;
            default: reg_addr = XFER_ADDR;
        endcase
    endfunction

    function automatic logic [7:0] reg_data(input logic [1:0] idx, input logic [7:0] v1,
                                            input logic [7:0] v2, input logic [7:0] v3);
        case (idx)
            2'd0:    reg_data = to_bcd(v1);
            2'd1:    reg_data = to_bcd(v2);
            2'd2:    reg_data = to_bcd(v3);
            default: reg_data = 8'h00;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    grp_q, grp_d;
    logic [7:0]    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [7:0]    bus_ad_q, bus_ad_d;
    logic          bus_oe_q, bus_oe_d;
    logic          cs_n_q, cs_n_d;
    logic          wr_n_q, wr_n_d;
    logic          a_d_q, a_d_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next state plus outputs derived from that next state, so every output is a flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        grp_d    = grp_q;
        v1_d     = v1_q;
        v2_d     = v2_q;
        v3_d     = v3_q;
        bus_ad_d = bus_ad_q;
        a_d_d    = a_d_q;
        bus_oe_d = 1'b0;
        cs_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (group != 2'd0)) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    grp_d   = group;
                    v1_d    = val_1;
                    v2_d    = val_2;
                    v3_d    = val_3;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_GAP_A;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_GAP_A: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_GAP_D;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_GAP_D: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADDR;
                    idx_d   = idx_q + 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_ADDR: begin
                bus_ad_d = reg_addr(grp_d, idx_d);
                a_d_d    = 1'b0;
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                bus_oe_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_DATA: begin
                bus_ad_d = reg_data(idx_d, v1_d, v2_d, v3_d);
                a_d_d    = 1'b1;
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                bus_oe_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_GAP_A, S_GAP_D: begin
                bus_oe_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_DONE: begin
                done_d   = 1'b1;
            end
            default: begin
                done_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            grp_q    <= 2'd0;
            v1_q     <= 8'h00;
            v2_q     <= 8'h00;
            v3_q     <= 8'h00;
            bus_ad_q <= 8'h00;
            bus_oe_q <= 1'b0;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            a_d_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            grp_q    <= grp_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            bus_ad_q <= bus_ad_d;
            bus_oe_q <= bus_oe_d;
            cs_n_q   <= cs_n_d;
            wr_n_q   <= wr_n_d;
            a_d_q    <= a_d_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign bus_ad = bus_ad_q;
    assign bus_oe = bus_oe_q;
    assign cs_n   = cs_n_q;
    assign wr_n   = wr_n_q;
    assign a_d    = a_d_q;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Scoreboard bench for rtc_write_sequencer: expected writes queued at start, popped per bus write.
module tb_rtc_write_sequencer;

    localparam int PC = 4;
`ifdef RTCW_XFER_CMD_EN
    localparam int K = 4;
`else
    localparam int K = 3;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] group = 2'd0;
    logic [7:0] val_1 = 8'd0;
    logic [7:0] val_2 = 8'd0;
    logic [7:0] val_3 = 8'd0;
    logic       busy, done, bus_oe, cs_n, wr_n, a_d;
    logic [7:0] bus_ad;

    rtc_write_sequencer #(.PHASE_CYCLES(PC)) dut (
        .clk(clk), .reset(reset), .start(start), .group(group),
        .val_1(val_1), .val_2(val_2), .val_3(val_3),
        .busy(busy), .done(done), .bus_ad(bus_ad), .bus_oe(bus_oe),
        .cs_n(cs_n), .wr_n(wr_n), .a_d(a_d)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] exp_q[$];
    logic [15:0] exp_w;
    logic        prev_cs = 1'b1;
    logic        prev_ad = 1'b1;
    logic [7:0]  prev_bus = 8'h00;
    logic [7:0]  cur_addr = 8'h00;
    int          run_len = 0;
    int          busy_len = 0;
    int          done_cnt = 0;
    int          cs_low_cnt = 0;

    // Bus monitor: phase timing, protocol invariants and scoreboard pops.
    always @(negedge clk) begin
        if (reset) begin
            run_len  = 0;
            busy_len = 0;
            prev_cs  = 1'b1;
            prev_ad  = 1'b1;
            prev_bus = 8'h00;
        end else begin
            check_val("cs_eq_wr", 32'(wr_n), 32'(cs_n));
            check_val("oe_eq_busy", 32'(bus_oe), 32'(busy));
            if (a_d !== prev_ad) check_val("a_d_change_cs_high", 32'(prev_cs), 32'd1);
            if (!cs_n) begin
                cs_low_cnt++;
                if (!prev_cs) check_val("phase_hold", 32'(bus_ad), 32'(prev_bus));
                run_len++;
            end else if (!prev_cs) begin
                check_val("phase_len", 32'(run_len), 32'(PC));
                run_len = 0;
                if (!prev_ad) begin
                    cur_addr = prev_bus;
                end else begin
                    check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        exp_w = exp_q.pop_front();
                        check_val("wr_addr", 32'(cur_addr), 32'(exp_w[15:8]));
                        check_val("wr_data", 32'(prev_bus), 32'(exp_w[7:0]));
                    end
                end
            end
            if (busy) busy_len++;
            if (done) begin
                done_cnt++;
                check_val("busy_len", 32'(busy_len), 32'(K * (2 * PC + 2)));
                check_val("sb_empty_at_done", 32'(exp_q.size()), 32'd0);
                busy_len = 0;
            end
            prev_cs  = cs_n;
            prev_ad  = a_d;
            prev_bus = bus_ad;
        end
    end

    // mode 0: plain, 1: scramble inputs one clock after start, 2: extra start mid-sequence
    task automatic run_commit(input logic [1:0] g, input logic [7:0] v1, input logic [7:0] v2,
                              input logic [7:0] v3, input logic [7:0] base, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input int mode);
        bit seen;
        exp_q.push_back({base, e1});
        exp_q.push_back({base + 8'd1, e2});
        exp_q.push_back({base + 8'd2, e3});
`ifdef RTCW_XFER_CMD_EN
        exp_q.push_back({8'hF1, 8'h00});
`endif
        start = 1'b1; group = g; val_1 = v1; val_2 = v2; val_3 = v3;
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_start", 32'(busy), 32'd1);
        check_val("cs_after_start", 32'(cs_n), 32'd0);
        check_val("addr_first", 32'(bus_ad), 32'(base));
        if (mode == 1) begin
            group = 2'd3; val_1 = 8'd1; val_2 = 8'd2; val_3 = 8'd3;
        end
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (mode == 2 && i == 10) begin
                start = 1'b1; group = 2'd1; val_1 = 8'd11; val_2 = 8'd22; val_3 = 8'd33;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check_val("done_seen", 32'(seen), 32'd1);
        check_val("busy_low_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        check_val("done_single_pulse", 32'(done), 32'd0);
        check_val("idle_after_done", 32'(busy), 32'd0);
    endtask

    int cs_before;
    int done_before;

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_bus_ad", 32'(bus_ad), 32'h00);
        check_val("rst_bus_oe", 32'(bus_oe), 32'd0);
        check_val("rst_cs_n", 32'(cs_n), 32'd1);
        check_val("rst_wr_n", 32'(wr_n), 32'd1);
        check_val("rst_a_d", 32'(a_d), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_commit(2'd3, 8'd45, 8'd30, 8'd13, 8'h21, 8'h45, 8'h30, 8'h13, 2);
        run_commit(2'd2, 8'd150, 8'd12, 8'd31, 8'h24, 8'h99, 8'h12, 8'h31, 1);
        run_commit(2'd1, 8'd0, 8'd59, 8'd23, 8'h41, 8'h00, 8'h59, 8'h23, 0);

        // group 0 request must be ignored entirely
        cs_before = cs_low_cnt;
        done_before = done_cnt;
        start = 1'b1; group = 2'd0; val_1 = 8'd7; val_2 = 8'd8; val_3 = 8'd9;
        @(negedge clk);
        start = 1'b0;
        check_val("g0_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        check_val("g0_no_cs", 32'(cs_low_cnt), 32'(cs_before));
        check_val("g0_no_done", 32'(done_cnt), 32'(done_before));

        // reset during the second register's data phase
        done_before = done_cnt;
        exp_q.push_back({8'h21, 8'h10});
        exp_q.push_back({8'h22, 8'h20});
        exp_q.push_back({8'h23, 8'h05});
        start = 1'b1; group = 2'd3; val_1 = 8'd10; val_2 = 8'd20; val_3 = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        check_val("mid_cs_low", 32'(cs_n), 32'd0);
        check_val("mid_data_phase", 32'(a_d), 32'd1);
        check_val("mid_data_value", 32'(bus_ad), 32'h20);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_mid_cs_n", 32'(cs_n), 32'd1);
        check_val("rst_mid_wr_n", 32'(wr_n), 32'd1);
        check_val("rst_mid_bus_oe", 32'(bus_oe), 32'd0);
        check_val("rst_mid_busy", 32'(busy), 32'd0);
        check_val("rst_mid_partial", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_val("rst_mid_no_done", 32'(done_cnt), 32'(done_before));

        run_commit(2'd3, 8'd59, 8'd59, 8'd23, 8'h21, 8'h59, 8'h59, 8'h23, 0);
        repeat (3) @(negedge clk);
        check_val("done_total", 32'(done_cnt), 32'd4);
        check_val("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_write_sequencer.md
# rtc_write_sequencer

Commits one edited group of three values (time, date or timer) to the external RTC over its multiplexed 8-bit address/data bus.

- Takes the binary values produced by the edit counter, converts each to packed BCD and runs one bus write cycle per register.
- Optionally issues a transfer command afterwards.
- Sits between the edit datapath and the RTC pins. It is the write-side counterpart of the RTC read path that feeds the edit counter.

## Interface

Parameters:
- PHASE_CYCLES, 4: clocks per bus phase (address or data), ≥1
- TIME_BASE, 8'h21: address of time seconds register; minutes +1, hours +2
- DATE_BASE, 8'h24: address of year register; month +1, day +2
- TIMER_BASE, 8'h41: address of timer seconds register; minutes +1, hours +2
- XFER_ADDR, 8'hF1: transfer-command address (used only with RTCW_XFER_CMD_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-clock commit request
- group  in  2  3 = time, 2 = date, 1 = timer, 0 = none
- val_1  in  8  binary seconds / year / timer seconds
- val_2  in  8  binary minutes / month / timer minutes
- val_3  in  8  binary hours / day / timer hours
- busy  out  1  sequence in progress
- done  out  1  one-clock pulse at end of sequence
- bus_ad  out  8  multiplexed address/data value
- bus_oe  out  1  bus drive enable
- cs_n  out  1  RTC chip select, active low
- wr_n  out  1  RTC write strobe, active low
- a_d  out  1  0 = address phase, 1 = data phase

## Operation

**Start and capture**
- Start is accepted only in IDLE, and only when `start`=1 and `group`≠0.
- On acceptance, `group`, `val_1`, `val_2` and `val_3` are captured into internal registers. Later input changes have no effect.
- Base address: group 3 → TIME_BASE, 2 → DATE_BASE, 1 → TIMER_BASE.
- Registers are written in this order:
  - base ← BCD(`val_1`)
  - base+1 ← BCD(`val_2`)
  - base+2 ← BCD(`val_3`)

**BCD conversion**
- Data byte = {tens[3:0], ones[3:0]} of the captured value.
- Values above 99 saturate to 8'h99.

**State machine:** IDLE → ADDR → GAP_A → DATA → GAP_D, then either
- → ADDR for the next register, or
- → XFER step (macro only), or
- → DONE → IDLE.

**Bus signals per state**
- ADDR: `bus_ad`=address, `a_d`=0, `cs_n`=0, `wr_n`=0, `bus_oe`=1; held for PHASE_CYCLES clocks.
- GAP_A and GAP_D: `cs_n`=1, `wr_n`=1, `bus_oe`=1, `bus_ad` held; 1 clock each.
- DATA: `bus_ad`=BCD data, `a_d`=1, `cs_n`=0, `wr_n`=0, `bus_oe`=1; held for PHASE_CYCLES clocks.
- DONE: `done`=1 and `busy`=0 for one clock, then IDLE.

**Boundary conditions**
- `start` while busy is ignored; no queuing.
- `start` with `group`=0 is ignored: no bus activity and no `done`.
- `reset` at any point returns to IDLE on that edge with all outputs at their reset values. A partial write is abandoned.

## Timing

- All outputs are registered.
- Reset values: `bus_ad`=8'h00, `bus_oe`=0, `cs_n`=1, `wr_n`=1, `a_d`=1, `busy`=0, `done`=0.
- `start` sampled at edge N → first ADDR clock and `busy`=1 from edge N+1.
- One register write = 2·PHASE_CYCLES + 2 clocks.
- Sequence length = k·(2·PHASE_CYCLES + 2) clocks, where k = 3 without the macro and k = 4 with it.
- `done` asserts in the clock immediately after the last GAP_D clock. `busy` is low during `done`.
- A new `start` may be accepted the clock after `done`.
- `cs_n` and `wr_n` are never low during GAP states. `a_d` changes only while `cs_n`=1.

## Configuration

- Macro `RTCW_XFER_CMD_EN` defined:
  - After the third register, one extra write cycle runs: XFER_ADDR ← 8'h00.
  - `done` follows that cycle.
- Macro undefined:
  - The sequence ends after the third register.
  - XFER_ADDR is unused.

## Test plan

All scenarios use PHASE_CYCLES=4.

- **Time commit:** group=3, val=45/30/13, pulse start.
  - Required: writes 21←45, 22←30, 23←13, each as an address phase then a data phase of 4 clocks.
  - Required: `busy` high 30 clocks, or 40 with the macro plus F1←00; then a single `done` pulse.
- **Date and saturation:** group=2, val=150/12/31.
  - Required: writes 24←99, 25←12, 26←31.
- **Timer commit:** group=1, val=0/59/23.
  - Required: writes 41←00, 42←59, 43←23.
- **Ignored starts:**
  - group=0 with `start`: no `cs_n` activity and no `done`.
  - Second `start` mid-sequence with different values: the bus carries only the first captured values.
- **Reset mid-op:** assert `reset` during the second register's DATA phase.
  - Required: next clock `cs_n`=1, `wr_n`=1, `bus_oe`=0, `busy`=0; no `done`.
  - Required: a subsequent `start` runs a full, correct sequence.
- **Input hold:** change `val_*` and `group` one clock after `start`.
  - Required: bus data matches the values captured at `start`.
